// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver and the producers that feed it.
// Segment bit order everywhere is {a,b,c,d,e,f,g,dp}, with 1 meaning lit.
package seg7_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  typedef logic [7:0] seg_pat_t;

  localparam seg_pat_t SEG_OFF = 8'h00;

  // Hex glyphs 0-F in {a,b,c,d,e,f,g,dp} order, dp dark
  localparam seg_pat_t HEX2SEG [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_ON    = 1'b1
  } slot_state_e;

  function automatic seg_pat_t hex2seg(input logic [3:0] nib, input logic dp);
    seg_pat_t pat;
    pat = HEX2SEG[nib];
    pat[SEG_DP] = dp;
    return pat;
  endfunction

  function automatic seg_pat_t seg_to_pins(input seg_pat_t pat);
    return ~pat;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot prescaler, digit-select counter and the BLANK/ON slot state machine.
// Exposes the current slot position plus a one-cycle lookahead used by the registered pins.
import seg7_pkg::*;

module seg7_slot_timer #(
  parameter int NDIG  = 8,
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] cur_sel,
  output logic       slot_first,
  output logic [2:0] sel_nxt,
  output logic       on_window,
  output logic       frame_first
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] P_LAST       = PW'(DIV - 1);
  localparam logic [PW-1:0] P_BLANK_LAST = PW'(BLANK - 1);
  localparam logic [2:0]    SEL_LAST     = 3'(NDIG - 1);

  logic [PW-1:0] p_q, p_d;
  logic [2:0]    sel_q, sel_d;
  logic          run_q, run_d;
  slot_state_e   state_q, state_d;

  // run_q is low only for the single idle cycle after reset; the next edge enters slot 0
  always_comb begin
    p_d     = p_q;
    sel_d   = sel_q;
    run_d   = 1'b1;
    state_d = state_q;
    if (!run_q) begin
      p_d     = '0;
      sel_d   = '0;
      state_d = SLOT_BLANK;
    end else if (p_q == P_LAST) begin
      p_d     = '0;
      sel_d   = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
      state_d = SLOT_BLANK;
    end else begin
      p_d = p_q + PW'(1);
      if (p_q == P_BLANK_LAST) begin
        state_d = SLOT_ON;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q     <= '0;
      sel_q   <= '0;
      run_q   <= 1'b0;
      state_q <= SLOT_BLANK;
    end else begin
      p_q     <= p_d;
      sel_q   <= sel_d;
      run_q   <= run_d;
      state_q <= state_d;
    end
  end

  assign cur_sel     = sel_q;
  assign slot_first  = run_q && (p_q == '0);
  assign sel_nxt     = sel_d;
  assign on_window   = (state_d == SLOT_ON);
  assign frame_first = (p_d == '0) && (sel_d == 3'd0);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-segment display driver with a double-buffered frame port.
// Frames are swapped only at the frame boundary, so a display never shows a torn frame.
import seg7_pkg::*;

module seg7_scan_driver #(
  parameter int NDIG  = 8,
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [8*NDIG-1:0] wr_data,
  output logic [7:0]        seg_n,
  output logic [NDIG-1:0]   dig_n,
  output logic [2:0]        cur_sel,
  output logic              frame_st
);

  logic [2:0] sel_nxt;
  logic       slot_first;
  logic       on_window;
  logic       frame_first;
  logic       boundary;
  logic       wr_fire;

  seg7_slot_timer #(
    .NDIG  (NDIG),
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .cur_sel     (cur_sel),
    .slot_first  (slot_first),
    .sel_nxt     (sel_nxt),
    .on_window   (on_window),
    .frame_first (frame_first)
  );

  // Buffers are sized for the full 3-bit digit index so the select never needs truncation
  seg_pat_t        pend_q   [8];
  seg_pat_t        pend_d   [8];
  seg_pat_t        shadow_q [8];
  seg_pat_t        shadow_d [8];
  logic            pend_full_q, pend_full_d;
  logic [7:0]      seg_n_q, seg_n_d;
  logic [NDIG-1:0] dig_n_q, dig_n_d;
  logic            frame_st_q, frame_st_d;

  assign boundary = slot_first && (cur_sel == 3'd0);
  assign wr_ready = !rst && !pend_full_q;
  assign wr_fire  = wr_valid && wr_ready;

  // A write can never coincide with the swap: it needs pend_full low, the swap needs it high
  always_comb begin
    pend_d      = pend_q;
    shadow_d    = shadow_q;
    pend_full_d = pend_full_q;
    if (boundary && pend_full_q) begin
      shadow_d    = pend_q;
      pend_full_d = 1'b0;
    end
    if (wr_fire) begin
      for (int k = 0; k < NDIG; k++) begin
        pend_d[k] = wr_data[8*k +: 8];
      end
      pend_full_d = 1'b1;
    end
  end

  // Pin registers are loaded from the timer lookahead so they move with the slot state
  always_comb begin
    seg_n_d    = seg_to_pins(SEG_OFF);
    dig_n_d    = '1;
    frame_st_d = frame_first;
    if (on_window) begin
      seg_n_d = seg_to_pins(shadow_d[sel_nxt]);
      for (int k = 0; k < NDIG; k++) begin
        if (sel_nxt == 3'(k)) begin
          dig_n_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '{default: '0};
      shadow_q    <= '{default: '0};
      pend_full_q <= 1'b0;
      seg_n_q     <= 8'hFF;
      dig_n_q     <= '1;
      frame_st_q  <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      shadow_q    <= shadow_d;
      pend_full_q <= pend_full_d;
      seg_n_q     <= seg_n_d;
      dig_n_q     <= dig_n_d;
      frame_st_q  <= frame_st_d;
    end
  end

  assign seg_n    = seg_n_q;
  assign dig_n    = dig_n_q;
  assign frame_st = frame_st_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle-level reference model, vector table and corner sequences
// on a small configuration, plus a frame-period check on the full-size configuration.
module tb_seg7_scan_driver;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FR    = NDIG * DIV;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic [7:0]  seg_n;
  logic [3:0]  dig_n;
  logic [2:0]  cur_sel;
  logic        frame_st;

  logic        rst_b = 1'b1;
  logic        wr_valid_b = 1'b0;
  logic [63:0] wr_data_b = '0;
  logic        wr_ready_b;
  logic [7:0]  seg_n_b;
  logic [7:0]  dig_n_b;
  logic [2:0]  cur_sel_b;
  logic        frame_st_b;

  seg7_scan_driver #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .seg_n(seg_n), .dig_n(dig_n), .cur_sel(cur_sel), .frame_st(frame_st)
  );

  seg7_scan_driver #(.NDIG(8), .DIV(1000), .BLANK(16)) dut_big (
    .clk(clk), .rst(rst_b), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_data(wr_data_b),
    .seg_n(seg_n_b), .dig_n(dig_n_b), .cur_sel(cur_sel_b), .frame_st(frame_st_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles counted since the slot-0 start, frames as whole words
  bit          mon_en = 1'b0;
  bit          m_started = 1'b0;
  int          m_cnt = 0;
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_data = '0;
  logic [31:0] m_shown = '0;
  bit          m_acc, m_bnd;
  logic [7:0]  e_seg;
  logic [3:0]  e_dig;
  int          e_cur, e_p;
  bit          e_fst;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mon_en = 1'b1;
        m_started = 1'b0;
        m_cnt = 0;
        m_pend = 1'b0;
        m_pend_data = '0;
        m_shown = '0;
      end else if (mon_en) begin
        m_acc = wr_valid && !m_pend;
        m_bnd = m_started && (m_cnt % FR == 0);
        if (m_bnd && m_pend) begin
          m_shown = m_pend_data;
          m_pend = 1'b0;
        end
        if (m_acc) begin
          m_pend = 1'b1;
          m_pend_data = wr_data;
        end
        if (!m_started) begin
          m_started = 1'b1;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      @(negedge clk);
      if (mon_en) begin
        e_seg = 8'hFF;
        e_dig = 4'hF;
        e_cur = 0;
        e_fst = 1'b0;
        if (m_started) begin
          e_p   = m_cnt % DIV;
          e_cur = (m_cnt / DIV) % NDIG;
          e_fst = (m_cnt % FR == 0);
          if (e_p >= BLANK) begin
            e_dig = ~(4'b0001 << e_cur);
            e_seg = ~m_shown[8*e_cur +: 8];
          end
        end
        chk("model_seg_n", {24'd0, seg_n}, {24'd0, e_seg});
        chk("model_dig_n", {28'd0, dig_n}, {28'd0, e_dig});
        chk("model_cur_sel", {29'd0, cur_sel}, e_cur);
        chk("model_frame_st", {31'd0, frame_st}, {31'd0, e_fst});
        chk("model_wr_ready", {31'd0, wr_ready}, {31'd0, (!rst && !m_pend)});
      end
    end
  end

  task automatic wait_frame();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_st === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_on(input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2*FR; i++) begin
      @(negedge clk);
      if (cur_sel == 3'(k) && dig_n[k] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_on_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_frame(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wr_data  = $urandom;
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [3];
  int   low_cnt [4];
  int   multi, stalls, lit, lows;
  bit   big_done = 1'b0;

  localparam logic [31:0] FRM_C = 32'h11223344;
  localparam logic [31:0] FRM_D = 32'h55667788;
  localparam logic [31:0] FRM_E = 32'h9ABCDEF0;
  localparam logic [31:0] FRM_F = 32'hFFFFFFFF;

  initial begin
    vecs[0] = '{data: 32'h065B4F66, exp: 32'hF9A4B099};
    vecs[1] = '{data: 32'h7F6D3F77, exp: 32'h8092C088};
    vecs[2] = '{data: 32'h66F2DA60, exp: 32'h990D259F};

    // Reset held for three edges
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk("rst_seg_n", {24'd0, seg_n}, 32'hFF);
      chk("rst_dig_n", {28'd0, dig_n}, 32'hF);
      chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
      chk("rst_frame_st", {31'd0, frame_st}, 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("post_rst_seg_n", {24'd0, seg_n}, 32'hFF);
    chk("post_rst_frame_st", {31'd0, frame_st}, 32'd0);
    @(negedge clk);
    chk("first_frame_st", {31'd0, frame_st}, 32'd1);

    // One frame of scan timing
    multi = 0;
    for (int k = 0; k < 4; k++) low_cnt[k] = 0;
    for (int i = 0; i < FR; i++) begin
      if (i > 0) @(negedge clk);
      for (int k = 0; k < 4; k++) if (dig_n[k] === 1'b0) low_cnt[k]++;
      if ($countones(~dig_n) > 1) multi++;
      if (i % DIV == 0) chk($sformatf("scan_cur_sel_slot%0d", i / DIV), {29'd0, cur_sel}, i / DIV);
    end
    for (int k = 0; k < 4; k++) chk($sformatf("scan_on_cycles_dig%0d", k), low_cnt[k], DIV - BLANK);
    chk("scan_never_two_low", multi, 0);
    @(negedge clk);
    chk("scan_cur_sel_wrap", {29'd0, cur_sel}, 32'd0);
    chk("scan_frame_period", {31'd0, frame_st}, 32'd1);

    // Vector table: mid-scan write, shown from the next frame
    for (int v = 0; v < 3; v++) begin
      repeat (5) @(posedge clk);
      #1;
      write_frame(vecs[v].data);
      @(negedge clk);
      chk($sformatf("vec%0d_rdy_drop", v), {31'd0, wr_ready}, 32'd0);
      wait_frame();
      for (int k = 0; k < 4; k++) begin
        wait_on(k);
        chk($sformatf("vec%0d_dig%0d_seg", v, k), {24'd0, seg_n}, {24'd0, vecs[v].exp[8*k +: 8]});
      end
      wait_frame();
    end

    // Back-pressure: D waits until the boundary frees the pending buffer
    repeat (3) @(posedge clk);
    #1;
    write_frame(FRM_C);
    wr_valid = 1'b1;
    wr_data  = FRM_D;
    stalls = 0;
    for (int i = 0; i < 3*FR; i++) begin
      @(negedge clk);
      if (wr_ready === 1'b1) break;
      stalls++;
    end
    chk("bp_stall_cycles", stalls, 29);
    chk("bp_release_cur_sel", {29'd0, cur_sel}, 32'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wait_on(0);
    chk("bp_frame_c_dig0", {24'd0, seg_n}, {24'd0, ~FRM_C[7:0]});
    wait_frame();
    wait_on(0);
    chk("bp_frame_d_dig0", {24'd0, seg_n}, {24'd0, ~FRM_D[7:0]});

    // Write accepted on the boundary cycle itself
    wait_frame();
    #1;
    wr_valid = 1'b1;
    wr_data  = FRM_E;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("bnd_write_rdy_drop", {31'd0, wr_ready}, 32'd0);
    wait_on(0);
    chk("bnd_write_still_old", {24'd0, seg_n}, {24'd0, ~FRM_D[7:0]});
    wait_frame();
    wait_on(0);
    chk("bnd_write_shown_next", {24'd0, seg_n}, {24'd0, ~FRM_E[7:0]});

    // Reset during an ON window with a frame pending
    @(posedge clk); #1;
    write_frame(FRM_F);
    wait_on(1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_seg_n", {24'd0, seg_n}, 32'hFF);
    chk("midrst_dig_n", {28'd0, dig_n}, 32'hF);
    @(posedge clk); #1 rst = 1'b0;
    lit = 0;
    lows = 0;
    for (int i = 0; i < 2*FR + 1; i++) begin
      @(negedge clk);
      if (seg_n !== 8'hFF) lit++;
      lows += 4 - $countones(dig_n);
    end
    chk("midrst_dark_after", lit, 0);
    chk("midrst_scan_continues", lows, 2 * NDIG * (DIV - BLANK));

    // Randomized traffic with occasional resets, checked by the model
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      wr_valid = ($urandom_range(0, 5) == 0);
      wr_data  = $urandom;
      rst      = ($urandom_range(0, 249) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wr_valid = 1'b0;
    repeat (2*FR) @(posedge clk);

    for (int i = 0; i < 20000 && !big_done; i++) @(posedge clk);
    if (!big_done) chk("big_timeout", 32'd0, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Full-size configuration: frame period and per-digit lit time
  int  b_cnt, b_on0, b_on5;
  bit  b_ok;
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    b_ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_st_b === 1'b1) begin
        b_ok = 1'b1;
        break;
      end
    end
    chk("big_first_frame_st", {31'd0, b_ok}, 32'd1);
    for (int f = 0; f < 2; f++) begin
      b_cnt = 0;
      b_on0 = 0;
      b_on5 = 0;
      for (int i = 0; i < 9000; i++) begin
        if (dig_n_b[0] === 1'b0) b_on0++;
        if (dig_n_b[5] === 1'b0) b_on5++;
        @(negedge clk);
        b_cnt++;
        if (frame_st_b === 1'b1) break;
      end
      chk($sformatf("big_period_f%0d", f), b_cnt, 8000);
      chk($sformatf("big_on_dig0_f%0d", f), b_on0, 984);
      chk($sformatf("big_on_dig5_f%0d", f), b_on5, 984);
    end
    big_done = 1'b1;
  end

endmodule
